// File: rtl/lc3_regfile_sb.sv
// lc3_regfile_sb: dual-write/dual-read register file with bypass, reservation scoreboard and NZP codes
module lc3_regfile_sb #(
  parameter int DATA_W = 16,
  parameter int NREG = 8,
  localparam int ADDR_W = $clog2(NREG)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] rd0_addr,
  input  logic [ADDR_W-1:0] rd1_addr,
  output logic [DATA_W-1:0] rd0_data,
  output logic [DATA_W-1:0] rd1_data,
  output logic              rd0_busy,
  output logic              rd1_busy,
  input  logic              wr0_en,
  input  logic              wr1_en,
  input  logic [ADDR_W-1:0] wr0_addr,
  input  logic [ADDR_W-1:0] wr1_addr,
  input  logic [DATA_W-1:0] wr0_data,
  input  logic [DATA_W-1:0] wr1_data,
  input  logic              cc_en,
  input  logic              rsv_en,
  input  logic [ADDR_W-1:0] rsv_addr,
  output logic              rsv_ok,
  output logic [NREG-1:0]   busy_vec,
  output logic [2:0]        nzp
);
  logic [DATA_W-1:0] regs_q [NREG];
  logic [DATA_W-1:0] regs_d [NREG];
  logic [NREG-1:0] busy_q, busy_d;
  logic [2:0] nzp_q, nzp_d;
  logic [DATA_W-1:0] rd0_mem, rd1_mem;
  logic rd0_in, rd1_in, rd0_bq, rd1_bq;
  logic rd0_w0, rd0_w1, rd1_w0, rd1_w1;
  always_comb begin
    rd0_mem = '0;
    rd1_mem = '0;
    rd0_in = 1'b0;
    rd1_in = 1'b0;
    rd0_bq = 1'b0;
    rd1_bq = 1'b0;
    rsv_ok = 1'b0;
    for (int i = 0; i < NREG; i++) begin
      if (rd0_addr == ADDR_W'(i)) begin
        rd0_mem = regs_q[i];
        rd0_bq = busy_q[i];
        rd0_in = 1'b1;
      end
      if (rd1_addr == ADDR_W'(i)) begin
        rd1_mem = regs_q[i];
        rd1_bq = busy_q[i];
        rd1_in = 1'b1;
      end
      if (rsv_addr == ADDR_W'(i)) rsv_ok = !busy_q[i];
    end
  end
  assign rd0_w0 = wr0_en && wr0_addr == rd0_addr;
  assign rd0_w1 = wr1_en && wr1_addr == rd0_addr;
  assign rd1_w0 = wr0_en && wr0_addr == rd1_addr;
  assign rd1_w1 = wr1_en && wr1_addr == rd1_addr;
  assign rd0_data = !rd0_in ? '0 : rd0_w1 ? wr1_data : rd0_w0 ? wr0_data : rd0_mem;
  assign rd1_data = !rd1_in ? '0 : rd1_w1 ? wr1_data : rd1_w0 ? wr0_data : rd1_mem;
  assign rd0_busy = rd0_bq && !(rd0_w0 || rd0_w1);
  assign rd1_busy = rd1_bq && !(rd1_w0 || rd1_w1);
  assign busy_vec = busy_q;
  assign nzp = nzp_q;
  // writes clear busy first so a same-cycle accepted reservation wins
  always_comb begin
    regs_d = regs_q;
    busy_d = busy_q;
    nzp_d = nzp_q;
    for (int i = 0; i < NREG; i++) begin
      if (wr0_en && wr0_addr == ADDR_W'(i)) begin
        regs_d[i] = wr0_data;
        busy_d[i] = 1'b0;
      end
      if (wr1_en && wr1_addr == ADDR_W'(i)) begin
        regs_d[i] = wr1_data;
        busy_d[i] = 1'b0;
      end
      if (rsv_en && rsv_ok && rsv_addr == ADDR_W'(i)) busy_d[i] = 1'b1;
    end
    if (wr0_en && cc_en)
      nzp_d = {wr0_data[DATA_W-1], ~|wr0_data, ~wr0_data[DATA_W-1] && |wr0_data};
    if (rst) begin
      for (int i = 0; i < NREG; i++) regs_d[i] = '0;
      busy_d = '0;
      nzp_d = 3'b010;
    end
  end
  always_ff @(posedge clk) begin
    regs_q <= regs_d;
    busy_q <= busy_d;
    nzp_q <= nzp_d;
  end
endmodule

// File: tb/tb_lc3_regfile_sb.sv
// tb_lc3_regfile_sb: vector table with scoreboard on the default instance, hand sequences on a NREG=6/DATA_W=32 instance
module tb_lc3_regfile_sb;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, wr0_en, wr1_en, cc_en, rsv_en, rsv_ok, rd0_busy, rd1_busy;
  logic [2:0] rd0_addr, rd1_addr, wr0_addr, wr1_addr, rsv_addr, nzp;
  logic [15:0] rd0_data, rd1_data, wr0_data, wr1_data;
  logic [7:0] busy_vec;

  logic b_rst, b_wr0_en, b_wr1_en, b_cc_en, b_rsv_en, b_rsv_ok, b_rd0_busy, b_rd1_busy;
  logic [2:0] b_rd0_addr, b_rd1_addr, b_wr0_addr, b_wr1_addr, b_rsv_addr, b_nzp;
  logic [31:0] b_rd0_data, b_rd1_data, b_wr0_data, b_wr1_data;
  logic [5:0] b_busy_vec;

  lc3_regfile_sb u0 (
    .clk(clk), .rst(rst), .rd0_addr(rd0_addr), .rd1_addr(rd1_addr),
    .rd0_data(rd0_data), .rd1_data(rd1_data), .rd0_busy(rd0_busy), .rd1_busy(rd1_busy),
    .wr0_en(wr0_en), .wr1_en(wr1_en), .wr0_addr(wr0_addr), .wr1_addr(wr1_addr),
    .wr0_data(wr0_data), .wr1_data(wr1_data), .cc_en(cc_en), .rsv_en(rsv_en),
    .rsv_addr(rsv_addr), .rsv_ok(rsv_ok), .busy_vec(busy_vec), .nzp(nzp)
  );

  lc3_regfile_sb #(.DATA_W(32), .NREG(6)) u1 (
    .clk(clk), .rst(b_rst), .rd0_addr(b_rd0_addr), .rd1_addr(b_rd1_addr),
    .rd0_data(b_rd0_data), .rd1_data(b_rd1_data), .rd0_busy(b_rd0_busy), .rd1_busy(b_rd1_busy),
    .wr0_en(b_wr0_en), .wr1_en(b_wr1_en), .wr0_addr(b_wr0_addr), .wr1_addr(b_wr1_addr),
    .wr0_data(b_wr0_data), .wr1_data(b_wr1_data), .cc_en(b_cc_en), .rsv_en(b_rsv_en),
    .rsv_addr(b_rsv_addr), .rsv_ok(b_rsv_ok), .busy_vec(b_busy_vec), .nzp(b_nzp)
  );

  typedef struct {
    logic rst; logic [2:0] ra0, ra1;
    logic w0e; logic [2:0] w0a; logic [15:0] w0d;
    logic w1e; logic [2:0] w1a; logic [15:0] w1d;
    logic cc, re; logic [2:0] rsa;
    logic [15:0] e0, e1; logic eb0, eb1, eok; logic [7:0] ebv; logic [2:0] enzp;
  } vec_t;

  typedef struct {
    logic [15:0] e0, e1; logic eb0, eb1, eok; logic [7:0] ebv; logic [2:0] enzp; int idx;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];
  int errs = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic b_idle();
    b_rst = 1'b0; b_wr0_en = 1'b0; b_wr1_en = 1'b0; b_cc_en = 1'b0; b_rsv_en = 1'b0;
    b_wr0_addr = 3'd0; b_wr1_addr = 3'd0; b_wr0_data = '0; b_wr1_data = '0;
    b_rsv_addr = 3'd0; b_rd0_addr = 3'd0; b_rd1_addr = 3'd0;
  endtask

  initial begin
    exp_t e;
    // {rst,ra0,ra1, w0e,w0a,w0d, w1e,w1a,w1d, cc,re,rsa, exp rd0,rd1,busy0,busy1,rsv_ok,busy_vec,nzp (pre-edge)}
    tbl.push_back('{1'b0,3'd0,3'd1, 1'b0,3'd0,16'h0000, 1'b0,3'd0,16'h0000, 1'b0,1'b0,3'd0, 16'h0000,16'h0000,1'b0,1'b0,1'b1,8'h00,3'b010});
    tbl.push_back('{1'b0,3'd3,3'd0, 1'b1,3'd3,16'h1234, 1'b0,3'd0,16'h0000, 1'b0,1'b0,3'd0, 16'h1234,16'h0000,1'b0,1'b0,1'b1,8'h00,3'b010});
    tbl.push_back('{1'b0,3'd3,3'd3, 1'b0,3'd0,16'h0000, 1'b0,3'd0,16'h0000, 1'b0,1'b0,3'd0, 16'h1234,16'h1234,1'b0,1'b0,1'b1,8'h00,3'b010});
    tbl.push_back('{1'b0,3'd3,3'd0, 1'b1,3'd3,16'h1234, 1'b0,3'd0,16'h0000, 1'b1,1'b0,3'd0, 16'h1234,16'h0000,1'b0,1'b0,1'b1,8'h00,3'b010});
    tbl.push_back('{1'b0,3'd5,3'd5, 1'b1,3'd5,16'hAAAA, 1'b1,3'd5,16'h5555, 1'b1,1'b0,3'd0, 16'h5555,16'h5555,1'b0,1'b0,1'b1,8'h00,3'b001});
    tbl.push_back('{1'b0,3'd5,3'd3, 1'b0,3'd0,16'h0000, 1'b0,3'd0,16'h0000, 1'b0,1'b0,3'd0, 16'h5555,16'h1234,1'b0,1'b0,1'b1,8'h00,3'b100});
    tbl.push_back('{1'b0,3'd2,3'd0, 1'b0,3'd0,16'h0000, 1'b0,3'd0,16'h0000, 1'b0,1'b1,3'd2, 16'h0000,16'h0000,1'b0,1'b0,1'b1,8'h00,3'b100});
    tbl.push_back('{1'b0,3'd2,3'd5, 1'b0,3'd0,16'h0000, 1'b0,3'd0,16'h0000, 1'b0,1'b1,3'd2, 16'h0000,16'h5555,1'b1,1'b0,1'b0,8'h04,3'b100});
    tbl.push_back('{1'b0,3'd2,3'd2, 1'b0,3'd0,16'h0000, 1'b1,3'd2,16'h0000, 1'b0,1'b0,3'd2, 16'h0000,16'h0000,1'b0,1'b0,1'b0,8'h04,3'b100});
    tbl.push_back('{1'b0,3'd2,3'd0, 1'b0,3'd0,16'h0000, 1'b0,3'd0,16'h0000, 1'b0,1'b0,3'd2, 16'h0000,16'h0000,1'b0,1'b0,1'b1,8'h00,3'b100});
    tbl.push_back('{1'b0,3'd4,3'd0, 1'b1,3'd4,16'h0042, 1'b0,3'd0,16'h0000, 1'b0,1'b1,3'd4, 16'h0042,16'h0000,1'b0,1'b0,1'b1,8'h00,3'b100});
    tbl.push_back('{1'b0,3'd4,3'd4, 1'b1,3'd4,16'h0077, 1'b0,3'd0,16'h0000, 1'b0,1'b1,3'd4, 16'h0077,16'h0077,1'b0,1'b0,1'b0,8'h10,3'b100});
    tbl.push_back('{1'b0,3'd4,3'd0, 1'b0,3'd0,16'h0000, 1'b0,3'd0,16'h0000, 1'b0,1'b0,3'd4, 16'h0077,16'h0000,1'b0,1'b0,1'b1,8'h00,3'b100});
    tbl.push_back('{1'b0,3'd1,3'd0, 1'b1,3'd1,16'h0000, 1'b0,3'd0,16'h0000, 1'b1,1'b0,3'd0, 16'h0000,16'h0000,1'b0,1'b0,1'b1,8'h00,3'b100});
    tbl.push_back('{1'b0,3'd1,3'd0, 1'b1,3'd1,16'h7FFF, 1'b0,3'd0,16'h0000, 1'b1,1'b0,3'd0, 16'h7FFF,16'h0000,1'b0,1'b0,1'b1,8'h00,3'b010});
    tbl.push_back('{1'b0,3'd1,3'd0, 1'b0,3'd1,16'h8000, 1'b0,3'd0,16'h0000, 1'b1,1'b0,3'd0, 16'h7FFF,16'h0000,1'b0,1'b0,1'b1,8'h00,3'b001});
    tbl.push_back('{1'b0,3'd6,3'd0, 1'b0,3'd0,16'h0000, 1'b1,3'd6,16'h8000, 1'b1,1'b0,3'd0, 16'h8000,16'h0000,1'b0,1'b0,1'b1,8'h00,3'b001});
    tbl.push_back('{1'b0,3'd6,3'd1, 1'b0,3'd0,16'h0000, 1'b0,3'd0,16'h0000, 1'b0,1'b1,3'd7, 16'h8000,16'h7FFF,1'b0,1'b0,1'b1,8'h00,3'b001});
    tbl.push_back('{1'b0,3'd7,3'd0, 1'b0,3'd0,16'h0000, 1'b1,3'd0,16'h0DEF, 1'b0,1'b0,3'd7, 16'h0000,16'h0DEF,1'b1,1'b0,1'b0,8'h80,3'b001});
    tbl.push_back('{1'b1,3'd7,3'd0, 1'b1,3'd7,16'h1111, 1'b0,3'd0,16'h0000, 1'b1,1'b1,3'd3, 16'h1111,16'h0DEF,1'b0,1'b0,1'b1,8'h80,3'b001});
    tbl.push_back('{1'b0,3'd7,3'd0, 1'b0,3'd0,16'h0000, 1'b0,3'd0,16'h0000, 1'b0,1'b0,3'd7, 16'h0000,16'h0000,1'b0,1'b0,1'b1,8'h00,3'b010});
    tbl.push_back('{1'b0,3'd7,3'd3, 1'b1,3'd3,16'h3333, 1'b1,3'd7,16'h2222, 1'b0,1'b0,3'd0, 16'h2222,16'h3333,1'b0,1'b0,1'b1,8'h00,3'b010});
    tbl.push_back('{1'b0,3'd7,3'd3, 1'b0,3'd0,16'h0000, 1'b0,3'd0,16'h0000, 1'b0,1'b0,3'd0, 16'h2222,16'h3333,1'b0,1'b0,1'b1,8'h00,3'b010});

    rst = 1'b1; wr0_en = 1'b0; wr1_en = 1'b0; cc_en = 1'b0; rsv_en = 1'b0;
    rd0_addr = 3'd0; rd1_addr = 3'd0; wr0_addr = 3'd0; wr1_addr = 3'd0; rsv_addr = 3'd0;
    wr0_data = '0; wr1_data = '0;
    b_idle();
    b_rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    b_rst = 1'b0;

    foreach (tbl[i]) begin
      rst = tbl[i].rst; rd0_addr = tbl[i].ra0; rd1_addr = tbl[i].ra1;
      wr0_en = tbl[i].w0e; wr0_addr = tbl[i].w0a; wr0_data = tbl[i].w0d;
      wr1_en = tbl[i].w1e; wr1_addr = tbl[i].w1a; wr1_data = tbl[i].w1d;
      cc_en = tbl[i].cc; rsv_en = tbl[i].re; rsv_addr = tbl[i].rsa;
      sb.push_back('{tbl[i].e0, tbl[i].e1, tbl[i].eb0, tbl[i].eb1, tbl[i].eok, tbl[i].ebv, tbl[i].enzp, i});
      #4;
      e = sb.pop_front();
      chk($sformatf("v%0d rd0_data", e.idx), 32'(rd0_data), 32'(e.e0));
      chk($sformatf("v%0d rd1_data", e.idx), 32'(rd1_data), 32'(e.e1));
      chk($sformatf("v%0d rd0_busy", e.idx), 32'(rd0_busy), 32'(e.eb0));
      chk($sformatf("v%0d rd1_busy", e.idx), 32'(rd1_busy), 32'(e.eb1));
      chk($sformatf("v%0d rsv_ok", e.idx), 32'(rsv_ok), 32'(e.eok));
      chk($sformatf("v%0d busy_vec", e.idx), 32'(busy_vec), 32'(e.ebv));
      chk($sformatf("v%0d nzp", e.idx), 32'(nzp), 32'(e.enzp));
      @(posedge clk);
      #1;
    end
    rst = 1'b0; wr0_en = 1'b0; wr1_en = 1'b0; cc_en = 1'b0; rsv_en = 1'b0;

    b_wr0_en = 1'b1; b_wr0_addr = 3'd7; b_wr0_data = 32'h12345678;
    b_wr1_en = 1'b1; b_wr1_addr = 3'd6; b_wr1_data = 32'h00000009;
    b_rsv_en = 1'b1; b_rsv_addr = 3'd7; b_rd0_addr = 3'd7; b_rd1_addr = 3'd6;
    #4;
    chk("oor bypass rd0", b_rd0_data, 32'h0);
    chk("oor bypass rd1", b_rd1_data, 32'h0);
    chk("oor rd0_busy", 32'(b_rd0_busy), 32'h0);
    chk("oor rsv_ok", 32'(b_rsv_ok), 32'h0);
    @(posedge clk);
    #1;
    b_idle();
    b_rd0_addr = 3'd7; b_rd1_addr = 3'd6; b_rsv_addr = 3'd6;
    #4;
    chk("oor rd0 after", b_rd0_data, 32'h0);
    chk("oor rd1 after", b_rd1_data, 32'h0);
    chk("oor rsv_ok 6", 32'(b_rsv_ok), 32'h0);
    chk("oor busy_vec", 32'(b_busy_vec), 32'h0);
    @(posedge clk);
    #1;
    b_wr0_en = 1'b1; b_wr0_addr = 3'd2; b_wr0_data = 32'h80000000; b_cc_en = 1'b1;
    b_rsv_en = 1'b1; b_rsv_addr = 3'd1; b_rd0_addr = 3'd2;
    #4;
    chk("w32 bypass", b_rd0_data, 32'h80000000);
    @(posedge clk);
    #1;
    b_idle();
    b_rd0_addr = 3'd2; b_rd1_addr = 3'd1; b_rsv_addr = 3'd1;
    #4;
    chk("w32 stored", b_rd0_data, 32'h80000000);
    chk("w32 rd1_busy", 32'(b_rd1_busy), 32'h1);
    chk("w32 rsv_ok", 32'(b_rsv_ok), 32'h0);
    chk("w32 busy_vec", 32'(b_busy_vec), 32'h02);
    chk("w32 nzp", 32'(b_nzp), 32'h4);
    @(posedge clk);
    #1;
    b_rst = 1'b1;
    b_wr0_en = 1'b1; b_wr0_addr = 3'd2; b_wr0_data = 32'hDEADBEEF; b_cc_en = 1'b1;
    b_wr1_en = 1'b1; b_wr1_addr = 3'd5; b_wr1_data = 32'hFFFFFFFF;
    b_rsv_en = 1'b1; b_rsv_addr = 3'd0;
    @(posedge clk);
    #1;
    b_idle();
    b_rd0_addr = 3'd2; b_rd1_addr = 3'd5; b_rsv_addr = 3'd1;
    #4;
    chk("rst rd0", b_rd0_data, 32'h0);
    chk("rst rd1", b_rd1_data, 32'h0);
    chk("rst rd0_busy", 32'(b_rd0_busy), 32'h0);
    chk("rst rsv_ok", 32'(b_rsv_ok), 32'h1);
    chk("rst busy_vec", 32'(b_busy_vec), 32'h0);
    chk("rst nzp", 32'(b_nzp), 32'h2);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/lc3_regfile_sb.md
# lc3_regfile_sb

Parametrised dual-write, dual-read general-purpose register file with per-register scoreboard and LC-3 condition-code register, for the pipelined LC-3 controller. Sits between decode, which reserves destinations and reads operands, and writeback, which has two ports: ALU/LEA retire and memory-load retire. Adds write-to-read bypass, reservation tracking so decode can stall on pending writes, and NZP generation on writeback.

## Interface
- DATA_W, 16, register width in bits (>= 2)
- NREG, 8, number of registers (2..32; need not be a power of two)
- ADDR_W, clog2(NREG), register address width (derived, not overridden)
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- rd0_addr, rd1_addr  in  ADDR_W  read-port addresses
- rd0_data, rd1_data  out  DATA_W  read data (combinational, bypassed)
- rd0_busy, rd1_busy  out  1  addressed register has an outstanding reservation not satisfied this cycle
- wr0_en, wr1_en  in  1  write enables; wr1 is the younger instruction
- wr0_addr, wr1_addr  in  ADDR_W  write addresses
- wr0_data, wr1_data  in  DATA_W  write data
- cc_en  in  1  update NZP from wr0_data when wr0_en is also high
- rsv_en  in  1  reserve rsv_addr as pending destination
- rsv_addr  in  ADDR_W  register to reserve
- rsv_ok  out  1  combinational: reservation of rsv_addr would be accepted this cycle
- busy_vec  out  NREG  registered scoreboard bits, bit r = register r pending
- nzp  out  3  condition codes {N,Z,P}, registered

## Operation
- Storage: NREG x DATA_W registers, scoreboard busy[NREG], 3-bit nzp.
- Write: on clock edge, each port with en high writes its data. If wr0_addr == wr1_addr with both enabled, wr1 data is stored; wr0 data is dropped.
- Read: rdX_data is selected in priority order:
  - wr1_data if wr1_en and wr1_addr == rdX_addr;
  - else wr0_data if wr0_en and wr0_addr == rdX_addr;
  - else the stored value.
- Read busy: rdX_busy = busy[rdX_addr] AND NOT (any enabled write to rdX_addr this cycle).
- Out-of-range addresses (>= NREG):
  - writes are ignored;
  - reads return 0 with busy 0;
  - reservations are rejected (rsv_ok 0).
- Scoreboard:
  - Any enabled write to r clears busy[r].
  - rsv_ok = busy[rsv_addr] == 0, evaluated on the pre-edge value.
  - An accepted reservation (rsv_en and rsv_ok) sets busy[rsv_addr].
  - Reservation and write to the same register in the same cycle:
    - if busy was 0, reservation accepted, result busy = 1;
    - if busy was 1, reservation rejected, write clears it, result busy = 0.
  - A rejected reservation has no effect. Decode must hold and retry.
- Condition codes: when wr0_en and cc_en, nzp is updated from wr0_data.
  - N = msb;
  - Z = all bits zero;
  - P = neither.
  - Exactly one bit is always set.
  - cc_en without wr0_en is ignored. wr1 never updates nzp.
  - nzp is updated even when wr0 data loses a same-address conflict to wr1.
- Reset: rst has priority over every write, reservation and cc update in the same cycle.

## Timing
- Reset values: all registers 0, busy_vec all 0, nzp = 3'b010. After reset, rdX_data is 0, rdX_busy is 0 and rsv_ok is 1 (in-range address).
- Write latency: 0 cycles via bypass, 1 cycle via storage (value visible from the array the cycle after the edge).
- rsv_ok and rdX_busy are combinational from current inputs and registered busy. busy_vec and nzp change only on clock edges.
- No combinational path from rsv_en to any output.
- Reset mid-operation clears outstanding reservations. Pending writebacks arriving after reset still write normally.

## Test plan
- Reset, then write R3=16'h1234 on wr0 -> same-cycle rd0_addr=3 reads 16'h1234; next cycle array read of R3 returns 16'h1234; nzp becomes 3'b001 only if cc_en was high.
- Same-cycle wr0 R5=16'hAAAA and wr1 R5=16'h5555 -> rd1 of R5 returns 16'h5555 both that cycle and the next; with cc_en, nzp = 3'b100 (from wr0 msb=1).
- Reserve R2 -> busy_vec[2]=1, rd0_busy=1 for R2, second rsv of R2 gives rsv_ok=0; wr1 to R2 with 16'h0000 -> rd0_busy=0 in that cycle, busy_vec[2]=0 next cycle.
- R4 idle: simultaneous rsv R4 and wr0 R4 -> busy_vec[4]=1 after edge. R4 busy: simultaneous rsv R4 and wr0 R4 -> busy_vec[4]=0, rsv rejected.
- cc_en with wr0_data 16'h0000 -> nzp=3'b010; 16'h7FFF -> 3'b001; cc_en with wr0_en=0 -> nzp unchanged.
- With NREG=6, DATA_W=32: write and reserve address 7 -> ignored, rd returns 0, rsv_ok=0. Assert rst with wr0_en, rsv_en and cc_en all high -> all registers 0, busy 0, nzp 3'b010.
